weight_addr_seq: RTL and testbench



---
 rtl/weight_addr_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_weight_addr_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_addr_seq.sv
// rtl/weight_addr_seq.sv - fold-major weight SRAM address sequencer with start/done FSM
// Optional WADDR_MARKERS_EN adds last_in_kernel / last_in_fold / last_addr beat markers.
module weight_addr_seq #(
    parameter int ADDR_W = 13,
    parameter int CH_W   = 6,
    parameter int K_W    = 3
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              abort,
    input  logic [CH_W-1:0]   cfg_c_in,
    input  logic [CH_W-1:0]   cfg_c_out,
    input  logic [K_W-1:0]    cfg_k,
    input  logic [CH_W-1:0]   cfg_ch_per_fold,
    input  logic [ADDR_W-1:0] cfg_base,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              fold_done,
    output logic              busy,
    output logic              done
`ifdef WADDR_MARKERS_EN
    ,
    output logic              last_in_kernel,
    output logic              last_in_fold,
    output logic              last_addr
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   c_in_q, c_in_d;
    logic [CH_W-1:0]   c_out_q, c_out_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [CH_W-1:0]   cpf_q, cpf_d;
    logic [ADDR_W-1:0] cinkk_q, cinkk_d;
    logic [ADDR_W-1:0] cpfkk_q, cpfkk_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] seg_q, seg_d;
    logic [ADDR_W-1:0] fold_q, fold_d;
    logic [K_W-1:0]    u_q, u_d;
    logic [K_W-1:0]    v_q, v_d;
    logic [CH_W-1:0]   i_q, i_d;
    logic [CH_W-1:0]   j_q, j_d;
    logic [CH_W-1:0]   o_q, o_d;
    logic [CH_W-1:0]   fstart_q, fstart_d;
    logic              fold_done_q, fold_done_d;

    // Per-layer products are formed once from the cfg inputs and registered at start;
    // the per-beat path below only adds.
    logic [ADDR_W-1:0] kk_w, cinkk_w, cpfkk_w;
    assign kk_w    = ADDR_W'(cfg_k) * ADDR_W'(cfg_k);
    assign cinkk_w = ADDR_W'(cfg_c_in) * kk_w;
    assign cpfkk_w = ADDR_W'(cfg_ch_per_fold) * kk_w;

    logic zero_cfg, u_last, v_last, i_last, o_last;
    logic seg_end, fold_end, fold_is_last, walk_end, beat;

    assign zero_cfg     = (cfg_c_in == '0) || (cfg_c_out == '0) || (cfg_k == '0) ||
                          (cfg_ch_per_fold == '0);
    assign u_last       = (u_q == k_q - 1'b1);
    assign v_last       = (v_q == k_q - 1'b1);
    assign i_last       = (j_q == cpf_q - 1'b1) || (i_q == c_in_q - 1'b1);
    assign o_last       = (o_q == c_out_q - 1'b1);
    assign seg_end      = u_last && v_last && i_last;
    assign fold_end     = seg_end && o_last;
    assign fold_is_last = ({1'b0, fstart_q} + {1'b0, cpf_q}) >= {1'b0, c_in_q};
    assign walk_end     = fold_end && fold_is_last;
    assign beat         = (state_q == RUN) && addr_ready;

    always_comb begin
        state_d     = state_q;
        c_in_d      = c_in_q;
        c_out_d     = c_out_q;
        k_d         = k_q;
        cpf_d       = cpf_q;
        cinkk_d     = cinkk_q;
        cpfkk_d     = cpfkk_q;
        addr_d      = addr_q;
        seg_d       = seg_q;
        fold_d      = fold_q;
        u_d         = u_q;
        v_d         = v_q;
        i_d         = i_q;
        j_d         = j_q;
        o_d         = o_q;
        fstart_d    = fstart_q;
        fold_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    c_in_d   = cfg_c_in;
                    c_out_d  = cfg_c_out;
                    k_d      = cfg_k;
                    cpf_d    = cfg_ch_per_fold;
                    cinkk_d  = cinkk_w;
                    cpfkk_d  = cpfkk_w;
                    addr_d   = cfg_base;
                    seg_d    = cfg_base;
                    fold_d   = cfg_base;
                    u_d      = '0;
                    v_d      = '0;
                    i_d      = '0;
                    j_d      = '0;
                    o_d      = '0;
                    fstart_d = '0;
                    state_d  = zero_cfg ? FIN : RUN;
                end
            end
            RUN: begin
                if (beat) begin
                    if (!u_last) begin
                        u_d = u_q + 1'b1;
                    end else begin
                        u_d = '0;
                        if (!v_last) begin
                            v_d = v_q + 1'b1;
                        end else begin
                            v_d = '0;
                            if (!i_last) begin
                                i_d = i_q + 1'b1;
                                j_d = j_q + 1'b1;
                            end else begin
                                j_d = '0;
                                if (!o_last) begin
                                    o_d = o_q + 1'b1;
                                    i_d = fstart_q;
                                end else begin
                                    o_d      = '0;
                                    fstart_d = fstart_q + cpf_q;
                                    i_d      = fstart_q + cpf_q;
                                end
                            end
                        end
                    end

                    // Each (fold, cout) segment is contiguous; only segment starts jump.
                    if (!seg_end) begin
                        addr_d = addr_q + 1'b1;
                    end else if (!o_last) begin
                        seg_d  = seg_q + cinkk_q;
                        addr_d = seg_q + cinkk_q;
                    end else begin
                        fold_d = fold_q + cpfkk_q;
                        seg_d  = fold_q + cpfkk_q;
                        addr_d = fold_q + cpfkk_q;
                    end

                    if (fold_end) begin
                        fold_done_d = 1'b1;
                    end
                    if (walk_end) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d     = IDLE;
            fold_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            c_in_q      <= '0;
            c_out_q     <= '0;
            k_q         <= '0;
            cpf_q       <= '0;
            cinkk_q     <= '0;
            cpfkk_q     <= '0;
            addr_q      <= '0;
            seg_q       <= '0;
            fold_q      <= '0;
            u_q         <= '0;
            v_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            o_q         <= '0;
            fstart_q    <= '0;
            fold_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            c_in_q      <= c_in_d;
            c_out_q     <= c_out_d;
            k_q         <= k_d;
            cpf_q       <= cpf_d;
            cinkk_q     <= cinkk_d;
            cpfkk_q     <= cpfkk_d;
            addr_q      <= addr_d;
            seg_q       <= seg_d;
            fold_q      <= fold_d;
            u_q         <= u_d;
            v_q         <= v_d;
            i_q         <= i_d;
            j_q         <= j_d;
            o_q         <= o_d;
            fstart_q    <= fstart_d;
            fold_done_q <= fold_done_d;
        end
    end

    assign addr       = addr_q;
    assign addr_valid = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == FIN);
    assign fold_done  = fold_done_q;

`ifdef WADDR_MARKERS_EN
    assign last_in_kernel = addr_valid && u_last && v_last;
    assign last_in_fold   = addr_valid && fold_end;
    assign last_addr      = addr_valid && walk_end;
`endif

endmodule

// File: tb/tb_weight_addr_seq.sv
// tb/tb_weight_addr_seq.sv - scoreboard bench for weight_addr_seq with a loop-nest reference model
module tb_weight_addr_seq;
    localparam int ADDR_W = 13;
    localparam int CH_W   = 6;
    localparam int K_W    = 3;

    logic              clk = 1'b0;
    logic              nrst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [CH_W-1:0]   cfg_c_in = '0;
    logic [CH_W-1:0]   cfg_c_out = '0;
    logic [K_W-1:0]    cfg_k = '0;
    logic [CH_W-1:0]   cfg_ch_per_fold = '0;
    logic [ADDR_W-1:0] cfg_base = '0;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic              addr_ready = 1'b1;
    logic              fold_done, busy, done;
`ifdef WADDR_MARKERS_EN
    logic              last_in_kernel, last_in_fold, last_addr;
`endif

    weight_addr_seq #(.ADDR_W(ADDR_W), .CH_W(CH_W), .K_W(K_W)) dut (
        .clk             (clk),
        .nrst            (nrst),
        .start           (start),
        .abort           (abort),
        .cfg_c_in        (cfg_c_in),
        .cfg_c_out       (cfg_c_out),
        .cfg_k           (cfg_k),
        .cfg_ch_per_fold (cfg_ch_per_fold),
        .cfg_base        (cfg_base),
        .addr            (addr),
        .addr_valid      (addr_valid),
        .addr_ready      (addr_ready),
        .fold_done       (fold_done),
        .busy            (busy),
        .done            (done)
`ifdef WADDR_MARKERS_EN
        ,
        .last_in_kernel  (last_in_kernel),
        .last_in_fold    (last_in_fold),
        .last_addr       (last_addr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic              fl;
        logic              lk;
        logic              la;
    } beat_t;

    beat_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    accepted = 0;
    int    rmode = 0;
    logic  exp_busy = 1'b0, exp_done = 1'b0, exp_fd = 1'b0;
    logic  stall_prev = 1'b0;
    logic [ADDR_W-1:0] held = '0;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the walk written directly as the nested loop of the layer description.
    task automatic build(input int ci, input int co, input int k, input int cpf, input int base);
        int nf, lo, hi, tmp;
        beat_t b;
        if (ci == 0 || co == 0 || k == 0 || cpf == 0) return;
        nf = (ci + cpf - 1) / cpf;
        for (int f = 0; f < nf; f++) begin
            lo = f * cpf;
            hi = ((f + 1) * cpf < ci) ? (f + 1) * cpf : ci;
            for (int o = 0; o < co; o++)
                for (int i = lo; i < hi; i++)
                    for (int v = 0; v < k; v++)
                        for (int u = 0; u < k; u++) begin
                            tmp  = base + ((o * ci + i) * k + v) * k + u;
                            b.a  = tmp[ADDR_W-1:0];
                            b.lk = (v == k - 1) && (u == k - 1);
                            b.fl = b.lk && (o == co - 1) && (i == hi - 1);
                            b.la = b.fl && (f == nf - 1);
                            exp_q.push_back(b);
                        end
        end
    endtask

    initial begin : ready_driver
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       addr_ready = 1'b1;
                1:       addr_ready = ~addr_ready;
                default: addr_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        logic nb, nd, nfd, ns;
        beat_t b;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                chk("rst_addr", addr, 0);
                chk("rst_valid", addr_valid, 0);
                chk("rst_fold_done", fold_done, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                exp_q.delete();
                exp_busy = 0; exp_done = 0; exp_fd = 0; stall_prev = 0;
            end else begin
                chk("busy", busy, exp_busy);
                chk("addr_valid", addr_valid, exp_busy);
                chk("done", done, exp_done);
                chk("fold_done", fold_done, exp_fd);
                if (stall_prev) chk("stall_hold", addr, held);
                nb = exp_busy; nd = 0; nfd = 0; ns = 0;
                if (abort) begin
                    exp_q.delete();
                    nb = 0;
                end else if (!exp_busy && !exp_done && start) begin
                    accepted = 0;
                    if (exp_q.size() == 0) nd = 1;
                    else nb = 1;
                end else if (exp_busy && addr_valid && addr_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("beat_underflow", 1, 0);
                        nb = 0;
                    end else begin
                        b = exp_q.pop_front();
                        chk("addr", addr, b.a);
`ifdef WADDR_MARKERS_EN
                        chk("last_in_kernel", last_in_kernel, b.lk);
                        chk("last_in_fold", last_in_fold, b.fl);
                        chk("last_addr", last_addr, b.la);
`endif
                        accepted++;
                        nfd = b.fl;
                        if (exp_q.size() == 0) begin
                            nb = 0;
                            nd = 1;
                        end
                    end
                end else if (exp_busy && addr_valid) begin
                    ns   = 1;
                    held = addr;
                end
                exp_busy = nb; exp_done = nd; exp_fd = nfd; stall_prev = ns;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_busy || exp_done || exp_fd) && n < 5000) begin
            cyc(1);
            n++;
        end
        if (n >= 5000) begin
            chk("walk_timeout", n, 0);
            exp_q.delete();
        end
        cyc(1);
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while (accepted < target && n < 2000) begin
            cyc(1);
            n++;
        end
        if (n >= 2000) chk("beat_wait_timeout", accepted, target);
    endtask

    task automatic launch(input int ci, input int co, input int k, input int cpf, input int base);
        build(ci, co, k, cpf, base);
        cfg_c_in        = CH_W'(ci);
        cfg_c_out       = CH_W'(co);
        cfg_k           = K_W'(k);
        cfg_ch_per_fold = CH_W'(cpf);
        cfg_base        = ADDR_W'(base);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cfg_c_in        = CH_W'($urandom);
        cfg_c_out       = CH_W'($urandom);
        cfg_k           = K_W'($urandom);
        cfg_ch_per_fold = CH_W'($urandom);
        cfg_base        = ADDR_W'($urandom);
    endtask

    task automatic walk(input int ci, input int co, input int k, input int cpf, input int base);
        launch(ci, co, k, cpf, base);
        wait_idle();
    endtask

    initial begin : stimulus
        #2 nrst = 1'b0;
        cyc(3);
        nrst = 1'b1;
        cyc(2);

        rmode = 0; walk(2, 2, 2, 1, 0);
        rmode = 1; walk(2, 2, 2, 1, 100);
        rmode = 0; walk(3, 1, 1, 2, 0);
        walk(2, 2, 0, 1, 0);

        launch(2, 2, 2, 1, 0);
        wait_beats(5);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        wait_idle();
        walk(2, 2, 2, 1, 0);

        launch(2, 2, 2, 1, 0);
        wait_beats(7);
        nrst = 1'b0;
        cyc(3);
        nrst = 1'b1;
        cyc(1);
        walk(2, 2, 2, 1, 0);

        rmode = 2; walk(3, 2, 3, 2, 8185);
        walk(5, 3, 2, 7, 300);

        for (int t = 0; t < 24; t++) begin
            rmode = $urandom_range(0, 2);
            walk($urandom_range(0, 6), $urandom_range(1, 4), $urandom_range(0, 3),
                 $urandom_range(1, 7), $urandom_range(0, 8191));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
